// File: rtl/obi_bank_arbiter_if.sv
// -----------------------------------------------------------------------------
// obi_bank_arbiter_if
// Bundles the OBI signals around one shared RAM bank: NREQ requesting masters
// on one side, a single bank port on the other.
//
// Handshake semantics (OBI, valid/ready style):
//   A request is offered while req=1 and accepted in the cycle where req=1 and
//   gnt=1 are both seen at the clock edge. The offering side keeps req and all
//   request fields (addr/we/be/wdata) stable until that cycle. The response
//   (rvalid/rdata) is a one-cycle pulse that cannot be back-pressured. Responses
//   come back in the order the requests were accepted.
//
// Signals
//   master_req/addr/we/be/wdata  [NREQ]  requests from the masters
//   master_gnt/rvalid/rdata      [NREQ]  grant and response back to each master
//   slave_req/addr/we/be/wdata           request forwarded to the RAM bank
//   slave_gnt/rvalid/rdata               grant and response from the RAM bank
//
// Modports
//   slave  : arbiter view (accepts master requests, drives the bank port)
//   master : environment view (masters plus RAM bank), the mirror image
// -----------------------------------------------------------------------------
interface obi_bank_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    logic [NREQ-1:0] master_req;
    logic [AW-1:0]   master_addr  [NREQ];
    logic [NREQ-1:0] master_we;
    logic [DW/8-1:0] master_be    [NREQ];
    logic [DW-1:0]   master_wdata [NREQ];
    logic [NREQ-1:0] master_gnt;
    logic [NREQ-1:0] master_rvalid;
    logic [DW-1:0]   master_rdata [NREQ];

    logic            slave_req;
    logic [AW-1:0]   slave_addr;
    logic            slave_we;
    logic [DW/8-1:0] slave_be;
    logic [DW-1:0]   slave_wdata;
    logic            slave_gnt;
    logic            slave_rvalid;
    logic [DW-1:0]   slave_rdata;

    modport slave (
        input  master_req, master_addr, master_we, master_be, master_wdata,
        output master_gnt, master_rvalid, master_rdata,
        output slave_req, slave_addr, slave_we, slave_be, slave_wdata,
        input  slave_gnt, slave_rvalid, slave_rdata
    );

    modport master (
        output master_req, master_addr, master_we, master_be, master_wdata,
        input  master_gnt, master_rvalid, master_rdata,
        input  slave_req, slave_addr, slave_we, slave_be, slave_wdata,
        output slave_gnt, slave_rvalid, slave_rdata
    );
endinterface

// File: rtl/obi_bank_arbiter.sv
// -----------------------------------------------------------------------------
// obi_bank_arbiter
// Shares one OBI RAM bank port between NREQ masters. Round-robin arbitration;
// a winner whose request is not granted immediately is locked until the bank
// grants it. The IDs of granted masters are kept in an owner FIFO so responses
// are routed back in order.
//
// Parameters
//   NREQ             number of requesting masters (>=2)
//   MAX_OUTSTANDING  max granted-but-unanswered transactions / owner FIFO depth
//
// Ports
//   clk_i          clock
//   rst_i          synchronous reset, active-high
//   bus            obi_bank_arbiter_if.slave (master and bank side signals)
//   outstanding_o  owner FIFO occupancy
//   err_o          sticky: rvalid arrived while no transaction was outstanding
//   lock_state_o   lock FSM state (1 = LOCKED), debug visibility
//   grant_cnt_o    [NREQ] 32-bit saturating grant counters   (OBI_BANK_ARB_PERF_EN)
//   stall_cnt_o    [NREQ] 32-bit saturating stall counters   (OBI_BANK_ARB_PERF_EN)
//
// Configuration
//   Define OBI_BANK_ARB_PERF_EN to add the per-master grant/stall counters.
//   Arbitration and timing are identical either way.
// -----------------------------------------------------------------------------
module obi_bank_arbiter #(
    parameter int NREQ            = 3,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    obi_bank_arbiter_if.slave                      bus,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   err_o,
    output logic                                   lock_state_o
`ifdef OBI_BANK_ARB_PERF_EN
    ,
    output logic [31:0]                            grant_cnt_o [NREQ],
    output logic [31:0]                            stall_cnt_o [NREQ]
`endif
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    lock_state_e    state_q;
    logic [IDW-1:0] lock_q;
    logic [IDW-1:0] rr_q;

    logic [IDW-1:0] fifo_q [MAX_OUTSTANDING];
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           err_q;

    logic [IDW-1:0] scan_idx;
    logic           scan_found;
    logic [IDW:0]   cand;
    logic [IDW-1:0] winner;
    logic           fifo_full;
    logic           fwd;
    logic           hs;
    logic           pop;
    logic           orphan_rvalid;
    logic [IDW-1:0] head_id;

    // Round-robin scan starting at rr_q. The candidate index is wrapped with an
    // explicit compare so non power-of-two NREQ never selects a missing master.
    always_comb begin
        scan_idx   = '0;
        scan_found = 1'b0;
        cand       = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!scan_found && bus.master_req[cand[IDW-1:0]]) begin
                scan_found = 1'b1;
                scan_idx   = cand[IDW-1:0];
            end
        end
    end

    assign winner    = (state_q == LOCKED) ? lock_q : scan_idx;
    // Full is judged on the registered count only: a pop this cycle does not
    // make room for a push in the same cycle.
    assign fifo_full = (count_q == CW'(MAX_OUTSTANDING));
    assign fwd       = bus.master_req[winner] && !fifo_full;
    assign hs        = fwd && bus.slave_gnt;

    assign pop           = bus.slave_rvalid && (count_q != '0);
    assign orphan_rvalid = bus.slave_rvalid && (count_q == '0);
    assign head_id       = fifo_q[rd_ptr_q];

    assign bus.slave_req   = fwd;
    assign bus.slave_addr  = bus.master_addr[winner];
    assign bus.slave_we    = bus.master_we[winner];
    assign bus.slave_be    = bus.master_be[winner];
    assign bus.slave_wdata = bus.master_wdata[winner];

    always_comb begin
        bus.master_gnt    = '0;
        bus.master_rvalid = '0;
        if (hs) begin
            bus.master_gnt[winner] = 1'b1;
        end
        if (pop) begin
            bus.master_rvalid[head_id] = 1'b1;
        end
    end

    // rdata is broadcast; only the master seeing rvalid uses it.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            bus.master_rdata[i] = bus.slave_rdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            lock_q   <= '0;
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (fwd && !bus.slave_gnt) begin
                        state_q <= LOCKED;
                        lock_q  <= winner;
                    end
                end
                LOCKED: begin
                    if (hs) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (hs) begin
                rr_q             <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
                fifo_q[wr_ptr_q] <= winner;
                wr_ptr_q         <= (wr_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
            end

            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
            end

            case ({hs, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            if (orphan_rvalid) begin
                err_q <= 1'b1;
            end
        end
    end

    assign outstanding_o = count_q;
    assign err_o         = err_q;
    assign lock_state_o  = (state_q == LOCKED);

`ifdef OBI_BANK_ARB_PERF_EN
    logic [31:0] grant_cnt_q [NREQ];
    logic [31:0] stall_cnt_q [NREQ];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NREQ; i++) begin
            if (rst_i) begin
                grant_cnt_q[i] <= '0;
                stall_cnt_q[i] <= '0;
            end else begin
                if (bus.master_gnt[i] && (grant_cnt_q[i] != 32'hFFFF_FFFF)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 32'd1;
                end
                if (bus.master_req[i] && !bus.master_gnt[i] &&
                    (stall_cnt_q[i] != 32'hFFFF_FFFF)) begin
                    stall_cnt_q[i] <= stall_cnt_q[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            grant_cnt_o[i] = grant_cnt_q[i];
            stall_cnt_o[i] = stall_cnt_q[i];
        end
    end
`endif
endmodule
